mips_register_file: RTL and testbench

- 32 x 32-bit general-purpose register file for the MIPS core datapath.
- Read side: decodes the rs/rt fields of the current instruction word and returns both operands, registered, to the ALU stage.
- Write side: accepts the ALU result for the rd field and commits it on the clock edge.
- Replaces the file-based register image currently used in simulation with synthesizable storage.

---
 rtl/mips_register_file.sv | 92 +++++++++
 tb/tb_mips_register_file.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_register_file.sv
// rtl/mips_register_file.sv - 32x32 MIPS register file, registered dual read, single write
// Optional write-before-read forwarding enabled by defining REGFILE_BYPASS_EN.
module mips_register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [31:0]       instruction_set,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [15:0]       wr_count
);

  localparam int NREG = 1 << ADDR_W;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  regs_q [NREG];
  logic [DATA_W-1:0]  rs_q, rs_d;
  logic [DATA_W-1:0]  rt_q, rt_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0]  rs_idx, rt_idx;
  logic               wr_fire;
  logic               unused_instr_bits;

  assign rs_idx  = instruction_set[21 +: ADDR_W];
  assign rt_idx  = instruction_set[16 +: ADDR_W];
  assign unused_instr_bits = ^{instruction_set[31:26], instruction_set[15:0]};

  // Register 0 is never written, so it stays at its reset value of zero.
  assign wr_fire = wr_en && (wr_addr != '0);

  always_comb begin
    state_d = rd_req ? RESP : IDLE;
  end

  always_comb begin
    rs_d = rs_q;
    rt_d = rt_q;
    if (rd_req) begin
      rs_d = (rs_idx == '0) ? '0 : regs_q[rs_idx];
      rt_d = (rt_idx == '0) ? '0 : regs_q[rt_idx];
`ifdef REGFILE_BYPASS_EN
      if (wr_fire && (wr_addr == rs_idx)) rs_d = wr_data;
      if (wr_fire && (wr_addr == rt_idx)) rt_d = wr_data;
`endif
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (wr_fire && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rs_q    <= '0;
      rt_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_fire) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  assign rs_data  = rs_q;
  assign rt_data  = rt_q;
  assign rd_valid = (state_q == RESP);
  assign wr_count = cnt_q;

endmodule

// File: tb/tb_mips_register_file.sv
// tb/tb_mips_register_file.sv - self-checking bench for mips_register_file
// Reference model plus directed vectors; honours REGFILE_BYPASS_EN.
module tb_mips_register_file;

  logic        clk;
  logic        rst_n;
  logic        rd_req;
  logic [31:0] instruction_set;
  logic [31:0] rs_data, rt_data;
  logic        rd_valid;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [15:0] wr_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  logic [31:0] m_regs [32];
  logic [31:0] exp_rs = '0;
  logic [31:0] exp_rt = '0;
  logic        exp_valid = 1'b0;
  int          m_writes = 0;

  mips_register_file dut (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .instruction_set(instruction_set),
    .rs_data(rs_data), .rt_data(rt_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_count(wr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mk_instr(input int rs, input int rt);
    logic [31:0] w;
    w = 32'h0;
    w[25:21] = rs[4:0];
    w[20:16] = rt[4:0];
    w[15:11] = 5'd1;
    return w;
  endfunction

  function automatic logic [31:0] rd_model(input int idx);
    logic [31:0] v;
    v = (idx == 0) ? 32'h0 : m_regs[idx];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr != 0 && int'(wr_addr) == idx) v = wr_data;
`endif
    return v;
  endfunction

  // Reference model: register array, a write counter and the last read result.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      exp_rs = 32'h0;
      exp_rt = 32'h0;
      exp_valid = 1'b0;
      m_writes = 0;
    end else begin
      exp_valid = rd_req;
      if (rd_req) begin
        exp_rs = rd_model(int'(instruction_set[25:21]));
        exp_rt = rd_model(int'(instruction_set[20:16]));
      end
      if (wr_en && wr_addr != 0) begin
        m_regs[wr_addr] = wr_data;
        m_writes++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_rd_valid", {31'h0, rd_valid}, {31'h0, exp_valid});
      check("cmp_rs_data", rs_data, exp_rs);
      check("cmp_rt_data", rt_data, exp_rt);
      check("cmp_wr_count", {16'h0, wr_count},
            (m_writes > 65535) ? 32'h0000_FFFF : 32'(m_writes));
    end
  end

  task automatic cyc(input logic rd, input logic [31:0] instr,
                     input logic we, input logic [4:0] wa, input logic [31:0] wd);
    rd_req = rd;
    instruction_set = instr;
    wr_en = we;
    wr_addr = wa;
    wr_data = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    #700000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rd_req = 1'b0; instruction_set = 32'h0;
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rd_valid", {31'h0, rd_valid}, 32'h0);
    check("reset_wr_count", {16'h0, wr_count}, 32'h0);
    check("reset_rs_data", rs_data, 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Write then read
    cyc(1'b0, 32'h0, 1'b1, 5'd10, 32'h7);
    cyc(1'b0, 32'h0, 1'b1, 5'd5, 32'h3);
    cyc(1'b1, 32'h01450820, 1'b0, 5'd0, 32'h0);
    check("wr_rd_rs", rs_data, 32'h7);
    check("wr_rd_rt", rt_data, 32'h3);
    check("wr_rd_valid", {31'h0, rd_valid}, 32'h1);
    check("wr_rd_count", {16'h0, wr_count}, 32'h2);
    idle();
    check("wr_rd_valid_drop", {31'h0, rd_valid}, 32'h0);
    check("hold_rs", rs_data, 32'h7);

    // Register 0
    cyc(1'b0, 32'h0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    cyc(1'b1, mk_instr(0, 0), 1'b0, 5'd0, 32'h0);
    check("r0_rs", rs_data, 32'h0);
    check("r0_count", {16'h0, wr_count}, 32'h2);

    // Same-cycle hazard
    cyc(1'b0, 32'h0, 1'b1, 5'd8, 32'h11);
    cyc(1'b1, mk_instr(8, 8), 1'b1, 5'd8, 32'h22);
`ifdef REGFILE_BYPASS_EN
    check("hazard_rs", rs_data, 32'h22);
    check("hazard_rt", rt_data, 32'h22);
`else
    check("hazard_rs", rs_data, 32'h11);
    check("hazard_rt", rt_data, 32'h11);
`endif
    cyc(1'b1, mk_instr(8, 0), 1'b0, 5'd0, 32'h0);
    check("hazard_next_rs", rs_data, 32'h22);
    check("hazard_next_rt", rt_data, 32'h0);

    // Bypass must never forward a register-0 write
    cyc(1'b1, mk_instr(0, 10), 1'b1, 5'd0, 32'hDEAD_BEEF);
    check("r0_nofwd_rs", rs_data, 32'h0);
    check("r0_nofwd_rt", rt_data, 32'h7);

    // Streaming reads
    cyc(1'b1, mk_instr(10, 5), 1'b0, 5'd0, 32'h0);
    check("stream0_rs", rs_data, 32'h7);
    cyc(1'b1, mk_instr(5, 8), 1'b1, 5'd3, 32'hA5A5_0001);
    check("stream1_rs", rs_data, 32'h3);
    check("stream1_rt", rt_data, 32'h22);
    cyc(1'b1, mk_instr(3, 10), 1'b0, 5'd0, 32'h0);
    check("stream2_rs", rs_data, 32'hA5A5_0001);
    cyc(1'b1, mk_instr(0, 3), 1'b0, 5'd0, 32'h0);
    check("stream3_rt", rt_data, 32'hA5A5_0001);
    check("stream3_valid", {31'h0, rd_valid}, 32'h1);
    idle();
    check("stream_drop", {31'h0, rd_valid}, 32'h0);

    // Reset mid-operation with a read and a write in flight
    rd_req = 1'b1; instruction_set = 32'h01450820;
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h99;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    rd_req = 1'b0; wr_en = 1'b0;
    rst_n = 1'b1;
    check("midrst_valid", {31'h0, rd_valid}, 32'h0);
    check("midrst_count", {16'h0, wr_count}, 32'h0);
    idle();
    check("midrst_valid_after", {31'h0, rd_valid}, 32'h0);
    cyc(1'b1, 32'h01450820, 1'b0, 5'd0, 32'h0);
    check("midrst_rs", rs_data, 32'h0);
    check("midrst_rt", rt_data, 32'h0);
    check("midrst_valid_rd", {31'h0, rd_valid}, 32'h1);

    // Saturation
    for (int i = 0; i < 65537; i++) begin
      cyc(1'b0, 32'h0, 1'b1, 5'(1 + (i % 31)), 32'(i));
    end
    check("sat_count", {16'h0, wr_count}, 32'h0000_FFFF);
    cyc(1'b0, 32'h0, 1'b1, 5'd4, 32'h1);
    cyc(1'b0, 32'h0, 1'b1, 5'd7, 32'h2);
    check("sat_hold", {16'h0, wr_count}, 32'h0000_FFFF);
    cyc(1'b1, mk_instr(4, 7), 1'b0, 5'd0, 32'h0);
    check("post_sat_rs", rs_data, 32'h1);
    check("post_sat_rt", rt_data, 32'h2);
    idle();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
